// File: rtl/chan_capture_ctrl.sv
// chan_capture_ctrl
//   Capture controller for one logic-analyzer channel group. It sequences the
//   pre-trigger fill, arming, trigger detection and post-trigger fill. It
//   drives the capture RAM write enable and a circular write address. It also
//   latches the address of the first post-trigger sample so that readout can
//   unroll the buffer.
//
//   Optional feature macro: CAPT_DECIM_EN. When it is defined, this block adds
//   a decim_i port and a sample prescaler.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   run_mode_i           level; starts a capture from IDLE
//   abort_i              returns to IDLE on the next edge; blocks this cycle's write
//   wrt_smpl_i           one-cycle sample strobe from the rate generator
//   trig_i               trigger condition (level)
//   trig_pos_i           number of post-trigger samples, clamped to ENTRIES-1
//   capture_done_i       completion status bit owned by the command processor
//   decim_i              (CAPT_DECIM_EN only) log2 of the decimation ratio
//   we_o / waddr_o       capture RAM write enable and write address
//   armed_o              pre-trigger fill complete
//   set_capture_done_o   one-cycle completion pulse
//   trig_addr_o          RAM address of the first post-trigger sample
//   capturing_o          high in every state except IDLE
module chan_capture_ctrl #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run_mode_i,
  input  logic            abort_i,
  input  logic            wrt_smpl_i,
  input  logic            trig_i,
  input  logic [LOG2-1:0] trig_pos_i,
  input  logic            capture_done_i,
`ifdef CAPT_DECIM_EN
  input  logic [3:0]      decim_i,
`endif
  output logic            we_o,
  output logic [LOG2-1:0] waddr_o,
  output logic            armed_o,
  output logic            set_capture_done_o,
  output logic [LOG2-1:0] trig_addr_o,
  output logic            capturing_o
);

  typedef enum logic [1:0] {S_IDLE, S_CAPT, S_DONE} state_t;

  localparam logic [LOG2-1:0] LAST_ADDR = LOG2'(ENTRIES - 1);
  // The pre-trigger threshold can equal ENTRIES (when tp==0), so it needs one extra bit.
  localparam logic [LOG2:0]   ENT_W     = (LOG2+1)'(ENTRIES);
  localparam logic [LOG2:0]   ONE_W     = (LOG2+1)'(1);
  localparam logic [LOG2-1:0] ONE_A     = LOG2'(1);

  state_t          state_q;
  logic [LOG2-1:0] waddr_q, trig_addr_q, tp_q, trig_cnt_q;
  logic [LOG2:0]   smpl_cnt_q;
  logic            armed_q, trig_seen_q, scd_q, cd_seen_q;

  logic [LOG2-1:0] tp_d, waddr_d, trig_cnt_d;
  logic [LOG2:0]   thr, smpl_cnt_d;
  logic            qs, we, trig_fire, last_post, done_now;

`ifdef CAPT_DECIM_EN
  logic [3:0]  decim_q, decim_d;
  logic [9:0]  presc_q, presc_mask;

  // Values above 10 are clamped to 10, so the prescaler needs 10 bits.
  assign decim_d    = (decim_i > 4'd10) ? 4'd10 : decim_i;
  assign presc_mask = 10'((11'(1) << decim_q) - 11'(1));
  // The prescaler is cleared at start. The first strobe after start is therefore the one that qualifies.
  assign qs         = wrt_smpl_i && (presc_q == '0);
`else
  assign qs         = wrt_smpl_i;
`endif

  assign tp_d       = (trig_pos_i > LAST_ADDR) ? LAST_ADDR : trig_pos_i;
  assign thr        = ENT_W - {1'b0, tp_q};
  assign we         = (state_q == S_CAPT) && qs && !abort_i;
  assign waddr_d    = (waddr_q == LAST_ADDR) ? '0 : waddr_q + ONE_A;
  assign smpl_cnt_d = smpl_cnt_q + ONE_W;
  assign trig_cnt_d = trig_cnt_q + ONE_A;

  // armed_q is registered, so a trigger can never be taken in the cycle where armed is being set.
  assign trig_fire  = (state_q == S_CAPT) && armed_q && !trig_seen_q && trig_i && !abort_i;
  assign last_post  = we && trig_seen_q && (tp_q != '0) && (trig_cnt_d == tp_q);
  assign done_now   = last_post || (trig_fire && (tp_q == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      waddr_q     <= '0;
      trig_addr_q <= '0;
      tp_q        <= '0;
      trig_cnt_q  <= '0;
      smpl_cnt_q  <= '0;
      armed_q     <= 1'b0;
      trig_seen_q <= 1'b0;
      scd_q       <= 1'b0;
      cd_seen_q   <= 1'b0;
`ifdef CAPT_DECIM_EN
      decim_q     <= '0;
      presc_q     <= '0;
`endif
    end else begin
      scd_q <= 1'b0;
      if (abort_i) begin
        // On abort, trig_addr keeps its last value, which is intended.
        state_q     <= S_IDLE;
        armed_q     <= 1'b0;
        trig_seen_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (run_mode_i && !capture_done_i) begin
              state_q     <= S_CAPT;
              smpl_cnt_q  <= '0;
              trig_cnt_q  <= '0;
              waddr_q     <= '0;
              armed_q     <= 1'b0;
              trig_seen_q <= 1'b0;
              tp_q        <= tp_d;
`ifdef CAPT_DECIM_EN
              decim_q     <= decim_d;
              presc_q     <= '0;
`endif
            end
          end
          S_CAPT: begin
            if (we) begin
              waddr_q <= waddr_d;
              if (trig_seen_q) begin
                trig_cnt_q <= trig_cnt_d;
              end else if (smpl_cnt_q != thr) begin
                // The pre-trigger count saturates at the threshold.
                smpl_cnt_q <= smpl_cnt_d;
                if (smpl_cnt_d == thr) armed_q <= 1'b1;
              end
            end
`ifdef CAPT_DECIM_EN
            if (wrt_smpl_i) presc_q <= (presc_q + 10'd1) & presc_mask;
`endif
            if (trig_fire) begin
              trig_seen_q <= 1'b1;
              // If a write coincides with the trigger, that write counts as pre-trigger.
              // The first post-trigger sample is then the next write.
              trig_addr_q <= we ? waddr_d : waddr_q;
            end
            if (done_now) begin
              state_q   <= S_DONE;
              scd_q     <= 1'b1;
              cd_seen_q <= 1'b0;
            end
          end
          S_DONE: begin
            // Return to IDLE only after the processor has raised capture_done and then dropped it.
            if (capture_done_i) begin
              cd_seen_q <= 1'b1;
            end else if (cd_seen_q) begin
              state_q     <= S_IDLE;
              armed_q     <= 1'b0;
              trig_seen_q <= 1'b0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign we_o               = we;
  assign waddr_o            = waddr_q;
  assign armed_o            = armed_q;
  assign set_capture_done_o = scd_q;
  assign trig_addr_o        = trig_addr_q;
  assign capturing_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_chan_capture_ctrl.sv
// Directed testbench for chan_capture_ctrl (ENTRIES=384, LOG2=9).
module tb_chan_capture_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run_mode, abort, wrt_smpl, trig, capture_done;
  logic [8:0] trig_pos;
  logic [3:0] decim;
  logic       we, armed, scd, capturing;
  logic [8:0] waddr, trig_addr;

  int n_chk = 0;
  int n_err = 0;
  int we_cnt = 0;
  logic [8:0] last_waddr = '0;

  always #5 clk = ~clk;

  chan_capture_ctrl #(.ENTRIES(384), .LOG2(9)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .run_mode_i         (run_mode),
    .abort_i            (abort),
    .wrt_smpl_i         (wrt_smpl),
    .trig_i             (trig),
    .trig_pos_i         (trig_pos),
    .capture_done_i     (capture_done),
`ifdef CAPT_DECIM_EN
    .decim_i            (decim),
`endif
    .we_o               (we),
    .waddr_o            (waddr),
    .armed_o            (armed),
    .set_capture_done_o (scd),
    .trig_addr_o        (trig_addr),
    .capturing_o        (capturing)
  );

  // Count RAM writes mid-cycle. Inputs change 1ns after the rising edge.
  always @(negedge clk) begin
    if (we) begin
      we_cnt++;
      last_waddr = waddr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [8:0] tp);
    trig_pos = tp;
    run_mode = 1'b1;
    cyc();
    run_mode = 1'b0;
    we_cnt   = 0;
  endtask

  task automatic wait_armed(input string tag);
    for (int i = 0; i < 2000; i++) begin
      if (armed) break;
      cyc();
    end
    chk(tag, armed, 1);
  endtask

  task automatic wait_scd(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (scd) break;
      cyc();
    end
    chk(tag, scd, 1);
  endtask

  task automatic release_done();
    wrt_smpl     = 1'b0;
    capture_done = 1'b1;
    cyc();
    capture_done = 1'b0;
    cyc();
  endtask

  initial begin
    rst_n = 1'b0; run_mode = 0; abort = 0; wrt_smpl = 0; trig = 0;
    capture_done = 0; trig_pos = '0; decim = '0;
    repeat (3) cyc();
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_armed", armed, 0);
    chk("rst_scd", scd, 0);
    chk("rst_trig_addr", trig_addr, 0);
    chk("rst_capturing", capturing, 0);
    rst_n = 1'b1;
    cyc();

    // Normal capture. A strobe in the start cycle must not write.
    trig_pos = 9'd8; run_mode = 1'b1; wrt_smpl = 1'b1;
    #2 chk("start_no_we", we, 0);
    cyc();
    run_mode = 1'b0; we_cnt = 0;
    chk("start_capturing", capturing, 1);
    wait_armed("norm_armed");
    chk("norm_arm_writes", we_cnt, 376);
    chk("norm_arm_waddr", waddr, 376);
    wrt_smpl = 1'b0; trig = 1'b1;
    cyc();
    trig = 1'b0; wrt_smpl = 1'b1;
    chk("norm_trig_addr", trig_addr, 376);
    wait_scd("norm_scd");
    chk("norm_writes", we_cnt, 384);
    chk("norm_wrap", waddr, 0);

    // Handshake: run_mode is held while capture_done=1 for 3 cycles.
    run_mode = 1'b1; capture_done = 1'b1;
    cyc();
    chk("scd_one_cycle", scd, 0);
    chk("hs_done1", capturing, 1);
    cyc();
    chk("hs_done2", capturing, 1);
    cyc();
    chk("hs_done3", capturing, 1);
    chk("hs_no_we", we_cnt, 384);
    capture_done = 1'b0;
    cyc();
    chk("hs_idle", capturing, 0);
    cyc();
    chk("hs_restart", capturing, 1);
    run_mode = 1'b0; we_cnt = 0;

    // Late trigger, asserted together with the 500th write.
    repeat (499) cyc();
    trig = 1'b1;
    cyc();
    trig = 1'b0;
    chk("late_pre_writes", we_cnt, 500);
    chk("late_trig_addr", trig_addr, 116);
    wait_scd("late_scd");
    chk("late_writes", we_cnt, 508);
    chk("late_last_addr", last_waddr, 123);
    release_done();
    chk("late_idle", capturing, 0);

    // Abort during the 200th write.
    start(9'd8);
    wrt_smpl = 1'b1;
    repeat (199) cyc();
    abort = 1'b1;
    #2 chk("abort_we", we, 0);
    cyc();
    abort = 1'b0; wrt_smpl = 1'b0;
    chk("abort_idle", capturing, 0);
    chk("abort_armed", armed, 0);
    chk("abort_trig_addr", trig_addr, 116);
    chk("abort_writes", we_cnt, 199);

    // trig_pos = 0
    start(9'd0);
    wrt_smpl = 1'b1;
    wait_armed("tp0_armed");
    chk("tp0_writes", we_cnt, 384);
    chk("tp0_waddr", waddr, 0);
    wrt_smpl = 1'b0; trig = 1'b1;
    cyc();
    trig = 1'b0;
    chk("tp0_scd", scd, 1);
    chk("tp0_no_extra_we", we_cnt, 384);
    chk("tp0_trig_addr", trig_addr, 0);
    release_done();

    // trig_pos = 500 is clamped to 383, so one write arms.
    start(9'd500);
    chk("tp500_not_armed", armed, 0);
    wrt_smpl = 1'b1;
    cyc();
    wrt_smpl = 1'b0;
    chk("tp500_armed", armed, 1);
    chk("tp500_writes", we_cnt, 1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("tp500_abort", capturing, 0);

`ifdef CAPT_DECIM_EN
    begin
      logic [15:0] wmask;
      wmask = '0;
      decim = 4'd2;
      start(9'd8);
      for (int p = 0; p < 16; p++) begin
        wrt_smpl = 1'b1;
        #2 if (we) wmask[p] = 1'b1;
        cyc();
        wrt_smpl = 1'b0;
        cyc();
      end
      chk("decim_writes", we_cnt, 4);
      chk("decim_pulses", {16'd0, wmask}, 32'h1111);
      abort = 1'b1;
      cyc();
      abort = 1'b0;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/chan_capture_ctrl.md
# chan_capture_ctrl

Parametrised capture controller for one logic-analyzer channel group, sitting between the sample-rate generator and the capture RAM. It sequences pre-trigger fill, arming, trigger detection and post-trigger fill. It drives RAM write-enable and a circular write address, and latches the RAM address where the trigger occurred so readout can unroll the buffer. It hands completion to the command processor through the `set_capture_done` / `capture_done` handshake.

## Interface
- `ENTRIES`, 384, capture RAM depth in samples; `2**LOG2 >= ENTRIES` is required.
- `LOG2`, 9, width of addresses and counters.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `run_mode` input 1: level; starts a capture from IDLE.
- `abort` input 1: forces return to IDLE.
- `wrt_smpl` input 1: one-cycle sample strobe from the rate generator.
- `trig` input 1: trigger condition, level.
- `trig_pos` input LOG2: number of post-trigger samples.
- `capture_done` input 1: status bit owned by the command processor.
- `decim` input 4: present only with `CAPT_DECIM_EN`.
- `we` output 1: RAM write enable.
- `waddr` output LOG2: RAM write address.
- `armed` output 1: pre-trigger fill complete.
- `set_capture_done` output 1: one-cycle completion pulse.
- `trig_addr` output LOG2: RAM address of the first post-trigger sample.
- `capturing` output 1: high in every state except IDLE.

## Operation
- **States:** IDLE, CAPTURE, DONE.
- **IDLE to CAPTURE:** taken when `run_mode=1 && capture_done=0`.
  - On entry, clear `smpl_cnt`, `trig_cnt`, `waddr`, `armed` and `trig_seen`.
  - Register `tp = min(trig_pos, ENTRIES-1)`; mid-capture changes to `trig_pos` are ignored.
- **Qualified strobe `qs`:** equals `wrt_smpl`, or the decimated strobe when `CAPT_DECIM_EN` is defined.
- **Write:** `we = (state==CAPTURE) & qs & ~abort` (combinational).
  - Each write advances `waddr` by 1, wrapping from `ENTRIES-1` to 0.
- **Pre-trigger count:** `smpl_cnt` increments on each write and saturates at `ENTRIES-tp`.
  - `armed` is set on the cycle after the write that makes `smpl_cnt == ENTRIES-tp`.
  - `armed` stays set until the next IDLE entry.
- **Trigger:** `trig_seen` sets on the first cycle with `armed && trig` while in CAPTURE; after that `trig` is ignored.
  - On that same edge, `trig_addr <= waddr`.
  - `trig` is not considered before `armed` is high, including the cycle in which `armed` is being set.
- **Post-trigger count:** each write with `trig_seen` set increments `trig_cnt`.
  - When `trig_cnt` reaches `tp`, assert `set_capture_done` for exactly one cycle and go to DONE.
  - When `tp==0`, this happens on the cycle after `trig_seen` sets, with no further writes.
- **DONE:** `we=0`.
  - Record when `capture_done` is seen high.
  - Go to IDLE on the first cycle where `capture_done=0` after it has been seen high.
- **Abort:** `abort=1` in any state goes to IDLE on the next edge.
  - `we` is suppressed in the abort cycle.
  - `armed` and `trig_seen` clear.
  - `trig_addr` keeps its last value.
- **Run-mode interlock:** `run_mode` is ignored while `capture_done=1` or outside IDLE.

## Timing
- **Reset values:** `we=0`, `waddr=0`, `armed=0`, `set_capture_done=0`, `trig_addr=0`, `capturing=0`; state is IDLE.
- **Start:** `run_mode` at edge N gives CAPTURE and `capturing=1` from N+1.
  - A `wrt_smpl` in cycle N does not write.
- **Write latency:** `we` has 0-cycle latency from `qs`.
  - `waddr` is valid during the `we` cycle and updates at the following edge.
- **Arming:** `armed` rises one cycle after the arming write.
  - The earliest trigger is recognised one cycle after that.
- **Completion:** `set_capture_done` rises on the cycle after the last post-trigger write, or the cycle after `trig_seen` sets when `tp==0`.
  - From then on `we` stays 0.
- **Simultaneous trigger and write:** when `trig_seen` sets on a cycle with `qs`, that write is counted as pre-trigger.
  - That write is at `trig_addr-1`; `trig_addr` is the next write's address.

## Configuration
- **`CAPT_DECIM_EN` defined:**
  - Adds the `decim` port, registered at IDLE to CAPTURE.
  - A prescaler counts `wrt_smpl` pulses and qualifies one in every `2**decim`, starting with the first pulse after start.
  - `decim` values above 10 are treated as 10.
- **`CAPT_DECIM_EN` undefined:** no `decim` port and no prescaler; `qs = wrt_smpl`.

## Test plan
- **Normal capture:** `ENTRIES=384`, `trig_pos=8`, `trig=0`, continuous `wrt_smpl`.
  - `armed` rises after the 376th write, with `waddr=376`.
  - Then `trig=1`: `trig_addr=376`, 8 more writes, `set_capture_done` for 1 cycle, and `waddr` wraps to 0.
- **Late trigger:** `trig_pos=8`, 500 writes before `trig=1`.
  - `trig_addr=116`, and `set_capture_done` follows the write at address 123.
  - Total of 508 `we` pulses.
- **Boundary `trig_pos`:**
  - `trig_pos=0`: `armed` after 384 writes; `trig=1` gives `set_capture_done` the next cycle with no extra `we`.
  - `trig_pos=500`: clamped to 383, so `armed` after 1 write.
- **Handshake:** after `set_capture_done`, hold `capture_done=1` for 3 cycles with `run_mode=1`.
  - The block stays in DONE.
  - Drop `capture_done`: IDLE next cycle, then restart the cycle after.
- **Abort mid-fill:** assert `abort` during the 200th write.
  - That write is suppressed, the block is in IDLE the next cycle with `armed=0`, and `trig_addr` is unchanged.
- **Decimation (`CAPT_DECIM_EN`):** `decim=2` and 16 `wrt_smpl` pulses.
  - Exactly 4 `we` pulses, on `wrt_smpl` pulses 1, 5, 9 and 13.
